// File: rtl/pwm_pkg.sv
// Shared encodings for the PWM timer sequencer: FSM states, pwm_gen function codes
// and default widths.
package pwm_pkg;
   localparam int CNT_W_DEFAULT   = 8;
   localparam int PRESC_W_DEFAULT = 8;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] RUN      = 2'd1;
   localparam logic [1:0] STOPPING = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE     = IDLE,
      ST_RUN      = RUN,
      ST_STOPPING = STOPPING
   } state_t;

   localparam logic [1:0] ALIGN_LEFT  = 2'd0;
   localparam logic [1:0] ALIGN_RIGHT = 2'd1;
   localparam logic [1:0] RANGE       = 2'd2;
endpackage

// File: rtl/pwm_timer_ctrl_if.sv
// Control/config bus between a host and pwm_timer_ctrl, plus the outputs to pwm_gen.
// start, stop and cfg_wr are single-cycle pulses with no back-pressure: each is acted
// on at the rising edge where it is high and is never held or acknowledged.
interface pwm_timer_ctrl_if #(
   parameter int CNT_W   = 8,
   parameter int PRESC_W = 8
);
   import pwm_pkg::*;

   logic               start;
   logic               stop;
   logic               cfg_oneshot;
   logic [PRESC_W-1:0] cfg_prescale;
   logic               cfg_wr;
   logic [CNT_W-1:0]   cfg_period;
   logic [CNT_W-1:0]   cfg_compare1;
   logic [CNT_W-1:0]   cfg_compare2;
   logic [1:0]         cfg_functions;

   logic [CNT_W-1:0]   counter_val;
   logic               pwm_en;
   logic [CNT_W-1:0]   period;
   logic [CNT_W-1:0]   compare1;
   logic [CNT_W-1:0]   compare2;
   logic [1:0]         functions;
   logic               period_done;
   logic               busy;
   state_t             dbg_state;

   modport master (
      output start, stop, cfg_oneshot, cfg_prescale, cfg_wr,
             cfg_period, cfg_compare1, cfg_compare2, cfg_functions,
      input  counter_val, pwm_en, period, compare1, compare2, functions,
             period_done, busy, dbg_state
   );

   modport slave (
      input  start, stop, cfg_oneshot, cfg_prescale, cfg_wr,
             cfg_period, cfg_compare1, cfg_compare2, cfg_functions,
      output counter_val, pwm_en, period, compare1, compare2, functions,
             period_done, busy, dbg_state
   );
endinterface

// File: rtl/pwm_prescaler.sv
// Clock prescaler: tick is high once every div+1 enabled clocks; held clear while disabled.
module pwm_prescaler #(
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [PRESC_W-1:0] div,
   output logic               tick
);
   logic [PRESC_W-1:0] presc_cnt;

   // div is read live; if it drops below presc_cnt the count rolls over before ticking.
   assign tick = en && (presc_cnt == div);

   always_ff @(posedge clk) begin
      if (!rst_n || !en || tick) begin
         presc_cnt <= '0;
      end else begin
         presc_cnt <= presc_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/pwm_timer_ctrl.sv
// Sequencer for pwm_gen: run/stop FSM, period counter and double-buffered configuration
// that only changes at a period wrap while running.
module pwm_timer_ctrl
   import pwm_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEFAULT,
   parameter int PRESC_W = PRESC_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   pwm_timer_ctrl_if.slave  bus
);
   state_t           state, state_nxt;
   logic             running, tick, wrap, start_go;
   logic             oneshot_q, done_q, pend_v;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] per_q, c1_q, c2_q;
   logic [1:0]       fn_q;
   logic [CNT_W-1:0] pend_per, pend_c1, pend_c2;
   logic [1:0]       pend_fn;

   assign running = (state != ST_IDLE);
   assign wrap    = tick && (cnt_q == per_q);

   pwm_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (running),
      .div   (bus.cfg_prescale),
      .tick  (tick)
   );

   always_comb begin
      state_nxt = state;
      start_go  = 1'b0;
      case (state)
         ST_IDLE: begin
            // stop in the same cycle cancels the start
            if (bus.start && !bus.stop) begin
               state_nxt = ST_RUN;
               start_go  = 1'b1;
            end
         end
         ST_RUN: begin
            if (wrap && oneshot_q) state_nxt = ST_IDLE;
            else if (bus.stop)     state_nxt = ST_STOPPING;
         end
         ST_STOPPING: begin
            if (wrap) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         oneshot_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= wrap;
         if (start_go) begin
            cnt_q     <= '0;
            oneshot_q <= bus.cfg_oneshot;
         end else if (state_nxt == ST_IDLE) begin
            cnt_q <= '0;
         end else if (tick) begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
         end
      end
   end

   // While running, writes are staged; the active set only moves at a wrap, so the
   // counter can never be above a freshly shrunk period.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         per_q    <= '0;
         c1_q     <= '0;
         c2_q     <= '0;
         fn_q     <= '0;
         pend_per <= '0;
         pend_c1  <= '0;
         pend_c2  <= '0;
         pend_fn  <= '0;
         pend_v   <= 1'b0;
      end else if (!running) begin
         if (bus.cfg_wr) begin
            per_q <= bus.cfg_period;
            c1_q  <= bus.cfg_compare1;
            c2_q  <= bus.cfg_compare2;
            fn_q  <= bus.cfg_functions;
         end
      end else begin
         if (wrap && pend_v) begin
            per_q <= pend_per;
            c1_q  <= pend_c1;
            c2_q  <= pend_c2;
            fn_q  <= pend_fn;
         end
         if (bus.cfg_wr) begin
            pend_per <= bus.cfg_period;
            pend_c1  <= bus.cfg_compare1;
            pend_c2  <= bus.cfg_compare2;
            pend_fn  <= bus.cfg_functions;
         end
         pend_v <= bus.cfg_wr || (pend_v && !wrap);
      end
   end

   assign bus.counter_val = cnt_q;
   assign bus.pwm_en      = running;
   assign bus.busy        = running;
   assign bus.period      = per_q;
   assign bus.compare1    = c1_q;
   assign bus.compare2    = c2_q;
   assign bus.functions   = fn_q;
   assign bus.period_done = done_q;
   assign bus.dbg_state   = state;
endmodule

// File: tb/tb_pwm_timer_ctrl.sv
// Bench for pwm_timer_ctrl: a hand-computed vector table, directed corner sequences and
// random traffic checked against a cycle-level behavioural model.
module tb_pwm_timer_ctrl;
   import pwm_pkg::*;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   int   cyc;

   pwm_timer_ctrl_if #(.CNT_W(8), .PRESC_W(8)) bus ();

   pwm_timer_ctrl #(.CNT_W(8), .PRESC_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int m_mode;            // 0 idle, 1 running, 2 finishing last period
   int m_cnt, m_pc, m_os, m_done;
   int m_per, m_c1, m_c2, m_fn;
   int p_per, p_c1, p_c2, p_fn, p_v;

   function automatic void model_step();
      bit tick, wrap;
      int nmode;
      if (!rst_n) begin
         m_mode = 0; m_cnt = 0; m_pc = 0; m_os = 0; m_done = 0;
         m_per = 0; m_c1 = 0; m_c2 = 0; m_fn = 0;
         p_per = 0; p_c1 = 0; p_c2 = 0; p_fn = 0; p_v = 0;
         return;
      end
      tick  = (m_mode != 0) && (m_pc == int'(bus.cfg_prescale));
      wrap  = tick && (m_cnt == m_per);
      nmode = m_mode;
      if (m_mode == 0 && bus.start && !bus.stop) nmode = 1;
      else if (m_mode == 1 && wrap && m_os != 0) nmode = 0;
      else if (m_mode == 1 && bus.stop) nmode = 2;
      else if (m_mode == 2 && wrap) nmode = 0;
      if (m_mode == 0) begin
         if (bus.cfg_wr) begin
            m_per = bus.cfg_period; m_c1 = bus.cfg_compare1;
            m_c2 = bus.cfg_compare2; m_fn = bus.cfg_functions;
         end
         m_pc = 0;
         if (nmode == 1) begin m_cnt = 0; m_os = bus.cfg_oneshot; end
      end else begin
         if (wrap && p_v != 0) begin
            m_per = p_per; m_c1 = p_c1; m_c2 = p_c2; m_fn = p_fn; p_v = 0;
         end
         if (bus.cfg_wr) begin
            p_per = bus.cfg_period; p_c1 = bus.cfg_compare1;
            p_c2 = bus.cfg_compare2; p_fn = bus.cfg_functions; p_v = 1;
         end
         if (tick) begin
            m_pc  = 0;
            m_cnt = wrap ? 0 : m_cnt + 1;
         end else begin
            m_pc = (m_pc + 1) % 256;
         end
         if (nmode == 0) begin m_cnt = 0; m_pc = 0; end
      end
      m_done = wrap ? 1 : 0;
      m_mode = nmode;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      bus.start  = 1'b0;
      bus.stop   = 1'b0;
      bus.cfg_wr = 1'b0;
   endtask

   task automatic drive_cfg(input int per, input int c1, input int c2, input int fn);
      bus.cfg_wr        = 1'b1;
      bus.cfg_period    = 8'(per);
      bus.cfg_compare1  = 8'(c1);
      bus.cfg_compare2  = 8'(c2);
      bus.cfg_functions = 2'(fn);
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string nm, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic chk_model(input string nm);
      logic [47:0] got, exp;
      got = {bus.counter_val, bus.period, bus.compare1, bus.compare2, bus.functions,
             bus.pwm_en, bus.busy, bus.period_done, 1'b0, bus.dbg_state, 2'b00};
      exp = {8'(m_cnt), 8'(m_per), 8'(m_c1), 8'(m_c2), 2'(m_fn),
             m_mode != 0, m_mode != 0, m_done != 0, 1'b0, 2'(m_mode), 2'b00};
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic step_chk(input string nm);
      step();
      chk_model(nm);
   endtask

   task automatic run_until_cnt(input string nm, input int target, input int budget);
      int k;
      k = 0;
      while (int'(bus.counter_val) != target && k < budget) begin
         step_chk(nm);
         k++;
      end
      chk({nm, "_reach_cnt"}, int'(bus.counter_val), target);
   endtask

   task automatic run_until_done(input string nm, input int budget);
      int k;
      k = 0;
      do begin
         step_chk(nm);
         k++;
      end while (!bus.period_done && k < budget);
      chk({nm, "_done_seen"}, int'(bus.period_done), 1);
   endtask

   task automatic run_until_idle(input string nm, input int budget);
      int k;
      k = 0;
      while (bus.busy && k < budget) begin
         step_chk(nm);
         k++;
      end
      chk({nm, "_idle"}, int'(bus.busy), 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit rst_n, start, stop, wr;
      int per;
      int e_cnt, e_busy, e_done, e_per;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit r, input bit s, input bit p, input bit w, input int per,
                      input int ec, input int eb, input int ed, input int ep);
      vec_t v;
      v.rst_n = r; v.start = s; v.stop = p; v.wr = w; v.per = per;
      v.e_cnt = ec; v.e_busy = eb; v.e_done = ed; v.e_per = ep;
      tbl.push_back(v);
   endtask

   initial begin
      int t0, t1, ndone, max_cnt;
      n_vec = 0; n_err = 0; cyc = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_oneshot = 1'b0;
      bus.cfg_prescale = 8'd0; bus.cfg_period = 8'd0; bus.cfg_compare1 = 8'd0;
      bus.cfg_compare2 = 8'd0; bus.cfg_functions = 2'd0;
      model_step();

      // prescale 0, period 7: reset, config, start, one full period, stop at 3, start+stop
      add(0, 0, 0, 0, 0,  0, 0, 0, 0);
      add(1, 0, 0, 1, 7,  0, 0, 0, 7);
      add(1, 1, 0, 0, 0,  0, 1, 0, 7);
      for (int i = 1; i <= 7; i++) add(1, 0, 0, 0, 0, i, 1, 0, 7);
      add(1, 0, 0, 0, 0,  0, 1, 1, 7);
      add(1, 0, 0, 0, 0,  1, 1, 0, 7);
      add(1, 0, 0, 0, 0,  2, 1, 0, 7);
      add(1, 0, 1, 0, 0,  3, 1, 0, 7);
      for (int i = 4; i <= 7; i++) add(1, 0, 0, 0, 0, i, 1, 0, 7);
      add(1, 0, 0, 0, 0,  0, 0, 1, 7);
      add(1, 1, 1, 0, 0,  0, 0, 0, 7);
      add(1, 0, 0, 0, 0,  0, 0, 0, 7);

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) begin
         rst_n = tbl[i].rst_n;
         bus.start = tbl[i].start;
         bus.stop  = tbl[i].stop;
         if (tbl[i].wr) drive_cfg(tbl[i].per, 3, 5, int'(ALIGN_RIGHT));
         step();
         chk($sformatf("tbl%0d_cnt", i),  int'(bus.counter_val), tbl[i].e_cnt);
         chk($sformatf("tbl%0d_busy", i), int'(bus.busy),        tbl[i].e_busy);
         chk($sformatf("tbl%0d_en", i),   int'(bus.pwm_en),      tbl[i].e_busy);
         chk($sformatf("tbl%0d_done", i), int'(bus.period_done), tbl[i].e_done);
         chk($sformatf("tbl%0d_per", i),  int'(bus.period),      tbl[i].e_per);
      end

      // prescale 2, period 3: counter steps every 3 clocks, wraps every 12
      bus.cfg_prescale = 8'd2;
      drive_cfg(3, 1, 2, int'(ALIGN_LEFT));
      step_chk("presc_cfg");
      bus.start = 1'b1;
      step_chk("presc_start");
      run_until_done("presc_w1", 40);
      t0 = cyc;
      run_until_done("presc_w2", 40);
      t1 = cyc;
      chk("presc_wrap_interval", t1 - t0, 12);
      bus.stop = 1'b1;
      step_chk("presc_stop");
      run_until_idle("presc_drain", 40);
      bus.cfg_prescale = 8'd0;

      // staged write mid-period takes effect only after the wrap
      drive_cfg(7, 3, 6, int'(ALIGN_LEFT));
      step_chk("shadow_cfg");
      bus.start = 1'b1;
      step_chk("shadow_start");
      run_until_cnt("shadow_to2", 2, 20);
      drive_cfg(4, 1, 2, int'(RANGE));
      step_chk("shadow_wr");
      chk("shadow_per_held", int'(bus.period), 7);
      run_until_done("shadow_wrap", 20);
      chk("shadow_per_new", int'(bus.period), 4);
      chk("shadow_c1_new", int'(bus.compare1), 1);
      max_cnt = 0;
      t0 = cyc;
      do begin
         step_chk("shadow_pass");
         if (int'(bus.counter_val) > max_cnt) max_cnt = int'(bus.counter_val);
      end while (!bus.period_done && cyc - t0 < 20);
      chk("shadow_max_cnt", max_cnt, 4);
      chk("shadow_pass_len", cyc - t0, 5);
      bus.stop = 1'b1;
      step_chk("shadow_stop");
      run_until_idle("shadow_drain", 20);

      // one-shot: single pass, one period_done, then idle
      drive_cfg(5, 2, 4, int'(ALIGN_LEFT));
      step_chk("os_cfg");
      bus.cfg_oneshot = 1'b1;
      bus.start = 1'b1;
      step_chk("os_start");
      bus.cfg_oneshot = 1'b0;
      ndone = 0;
      t0 = cyc;
      while (bus.busy && cyc - t0 < 20) begin
         step_chk("os_run");
         if (bus.period_done) ndone++;
      end
      chk("os_done_count", ndone, 1);
      chk("os_busy", int'(bus.busy), 0);
      chk("os_en", int'(bus.pwm_en), 0);
      chk("os_cnt", int'(bus.counter_val), 0);
      step_chk("os_quiet");
      chk("os_no_second_done", int'(bus.period_done), 0);

      // reset mid-run with a pending write discards everything
      drive_cfg(7, 3, 5, int'(ALIGN_RIGHT));
      step_chk("rst_cfg");
      bus.start = 1'b1;
      step_chk("rst_start");
      run_until_cnt("rst_to1", 1, 10);
      drive_cfg(2, 1, 1, int'(RANGE));
      step_chk("rst_pend");
      run_until_cnt("rst_to5", 5, 10);
      rst_n = 1'b0;
      step_chk("rst_apply");
      chk("rst_cnt", int'(bus.counter_val), 0);
      chk("rst_per", int'(bus.period), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_c1", int'(bus.compare1), 0);
      rst_n = 1'b1;
      bus.start = 1'b1;
      step_chk("rst_restart");
      chk("rst_restart_per", int'(bus.period), 0);
      step_chk("rst_p0_wrap");
      chk("rst_p0_done", int'(bus.period_done), 1);
      step_chk("rst_p0_wrap2");
      chk("rst_p0_done2", int'(bus.period_done), 1);
      bus.stop = 1'b1;
      step_chk("rst_stop");
      run_until_idle("rst_drain", 10);

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         bus.start = ($urandom_range(0, 11) == 0);
         bus.stop  = ($urandom_range(0, 23) == 0);
         if ($urandom_range(0, 7) == 0)
            drive_cfg($urandom_range(0, 9), $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 2));
         bus.cfg_oneshot = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) bus.cfg_prescale = 8'($urandom_range(0, 3));
         step_chk("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
